// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receive FSM states, oversampling ratio.
// Also intended for the transmit side.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int OSR    = 16;
  localparam int OSR_W  = $clog2(OSR);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_STOP2
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received words.
//  clock, reset     : system clock, synchronous active-high reset
//  push, push_data  : write request and word
//  pop              : consumer ready; an entry is removed when valid & pop
//  head, valid      : current head word (0 when empty), FIFO not empty
//  count            : occupancy
//  overrun          : sticky, set when a push is dropped on a full FIFO
//  overrun_clr      : clears overrun (a same-cycle set wins)
module uart_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     overrun_clr
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  assign valid = ~empty;
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & ~do_push)  overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling, 3-sample majority vote at
// oc=7/8/9, 5..9 data bits, none/even/odd parity, 1 or 2 stop bits.
//  clock, reset    : system clock, synchronous active-high reset
//  rx_pin_in       : asynchronous serial line, idle high
//  rx_data_out, rx_parity_err, rx_frame_err, rx_valid, rx_ready : FWFT FIFO head + handshake
//  rx_overrun, overrun_clr : sticky drop flag and its clear
//  rx_busy         : receive FSM not idle
//  fifo_count      : FIFO occupancy
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_pin_in,
  output logic [DATA_BITS-1:0]          rx_data_out,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  input  logic                          overrun_clr,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int OSR_DIV = CLK_FREQ / (BAUD * OSR);
  localparam int DW      = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam int BW      = $clog2(DATA_BITS);

  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } rx_word_t;

  rx_state_t            state, state_nx;
  logic [1:0]           sync;
  logic                 line, armed;
  logic [DW-1:0]        div_cnt;
  logic [OSR_W-1:0]     oc;
  logic                 os_tick, mid, end_bit, maj;
  logic                 s7, s8;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, ferr_acc;
  logic                 push;
  rx_word_t             push_word, head_word;

  assign line    = sync[1];
  // Divider is parked in IDLE so the first tick lands one clock after the start edge.
  assign os_tick = (state != ST_IDLE) && (div_cnt == DW'(OSR_DIV - 1));
  assign mid     = os_tick && (oc == OSR_W'(9));
  assign end_bit = os_tick && (oc == OSR_W'(15));
  // Current line plays the role of the oc=9 sample.
  assign maj     = (s7 & s8) | (s7 & line) | (s8 & line);
  assign rx_busy = (state != ST_IDLE);

  assign push_word.frame_err  = ferr_acc | ~maj;
  assign push_word.parity_err = par_err;
  assign push_word.data       = shreg;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    case (state)
      ST_IDLE:   if (armed && !line) state_nx = ST_START;
      ST_START:  if (mid && maj)     state_nx = ST_IDLE;
                 else if (end_bit)   state_nx = ST_DATA;
      ST_DATA:   if (end_bit && bit_cnt == BW'(DATA_BITS - 1))
                   state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (end_bit) state_nx = ST_STOP;
      ST_STOP: begin
        if (STOP_BITS == 2) begin
          if (end_bit) state_nx = ST_STOP2;
        end else if (mid) begin
          push     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_STOP2:  if (mid) begin
                   push     = 1'b1;
                   state_nx = ST_IDLE;
                 end
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync     <= 2'b11;
      armed    <= 1'b0;
      div_cnt  <= '0;
      oc       <= '0;
      s7       <= 1'b0;
      s8       <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_err  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      sync <= {sync[0], rx_pin_in};
      // Only re-arm after the line has been seen high, so a held break yields one word.
      armed <= (state == ST_IDLE) ? line : 1'b0;
      if (state == ST_IDLE) begin
        div_cnt  <= '0;
        oc       <= '0;
        bit_cnt  <= '0;
        par_err  <= 1'b0;
        ferr_acc <= 1'b0;
      end else begin
        div_cnt <= os_tick ? '0 : div_cnt + 1'b1;
        if (os_tick) begin
          oc <= oc + 1'b1;
          if (oc == OSR_W'(7)) s7 <= line;
          if (oc == OSR_W'(8)) s8 <= line;
        end
        if (state == ST_DATA && mid)     shreg   <= {maj, shreg[DATA_BITS-1:1]};
        if (state == ST_DATA && end_bit) bit_cnt <= bit_cnt + 1'b1;
        if (state == ST_PARITY && mid)
          par_err <= (^shreg) ^ maj ^ (PARITY == PAR_ODD);
        if (state == ST_STOP && mid)     ferr_acc <= ferr_acc | ~maj;
      end
    end
  end

  uart_rx_fifo #(
    .W     ($bits(rx_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .push_data   (push_word),
    .pop         (rx_ready),
    .head        (head_word),
    .valid       (rx_valid),
    .count       (fifo_count),
    .overrun     (rx_overrun),
    .overrun_clr (overrun_clr)
  );

  assign rx_data_out   = head_word.data;
  assign rx_parity_err = head_word.parity_err;
  assign rx_frame_err  = head_word.frame_err;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: three receivers (8N1, 8E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_param;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       line [3];
  logic [7:0] dout [3];
  logic       perr [3], ferr [3], vld [3], rdy [3], ovr [3], oclr [3], busy [3];
  logic [2:0] cnt  [3];

  int         n_vec = 0, n_err = 0;
  int         pops [3];
  logic [9:0] last [3];

  always #5 clock = ~clock;

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
    .clock(clock), .reset(reset), .rx_pin_in(line[0]), .rx_data_out(dout[0]),
    .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_valid(vld[0]), .rx_ready(rdy[0]),
    .rx_overrun(ovr[0]), .overrun_clr(oclr[0]), .rx_busy(busy[0]), .fifo_count(cnt[0]));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
    .clock(clock), .reset(reset), .rx_pin_in(line[1]), .rx_data_out(dout[1]),
    .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_valid(vld[1]), .rx_ready(rdy[1]),
    .rx_overrun(ovr[1]), .overrun_clr(oclr[1]), .rx_busy(busy[1]), .fifo_count(cnt[1]));

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
    .clock(clock), .reset(reset), .rx_pin_in(line[2]), .rx_data_out(dout[2]),
    .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]), .rx_valid(vld[2]), .rx_ready(rdy[2]),
    .rx_overrun(ovr[2]), .overrun_clr(oclr[2]), .rx_busy(busy[2]), .fifo_count(cnt[2]));

  // Record every word the consumer takes: {frame_err, parity_err, data}.
  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (vld[k] && rdy[k]) begin
        pops[k] <= pops[k] + 1;
        last[k] <= {ferr[k], perr[k], dout[k]};
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Bits LSB first, 16 clocks each; optional one-clock inversion at offset 9 of bit gl.
  task automatic send_bits(input int k, input logic [15:0] bits, input int n, input int gl);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 16; c++) begin
        line[k] = bits[b] ^ ((b == gl) && (c == 9));
        tick(1);
      end
    end
    line[k] = 1'b1;
  endtask

  task automatic expect_word(input string tag, input int k, input int p0,
                             input int d, input int pe, input int fe);
    chk({tag, "_pops"}, pops[k] - p0, 1);
    chk({tag, "_data"}, int'(last[k][7:0]), d);
    chk({tag, "_perr"}, int'(last[k][8]), pe);
    chk({tag, "_ferr"}, int'(last[k][9]), fe);
  endtask

  int p0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      line[k] = 1'b1; rdy[k] = 1'b1; oclr[k] = 1'b0; pops[k] = 0; last[k] = '0;
    end
    tick(4);
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", vld[k], 0);
      chk("rst_busy",  busy[k], 0);
      chk("rst_count", cnt[k], 0);
      chk("rst_ovr",   ovr[k], 0);
      chk("rst_data",  dout[k], 0);
    end
    reset = 1'b0;
    tick(8);

    // 8N1 0xA5
    p0 = pops[0];
    send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1);
    tick(8);
    expect_word("n1_a5", 0, p0, 8'hA5, 0, 0);
    chk("n1_a5_vld_after", vld[0], 0);

    // 8E1 0x03: parity of data is 0, so bit 1 is wrong and bit 0 correct
    p0 = pops[1];
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1);
    tick(8);
    expect_word("e1_bad", 1, p0, 8'h03, 1, 0);
    p0 = pops[1];
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, -1);
    tick(8);
    expect_word("e1_good", 1, p0, 8'h03, 0, 0);

    // 4-clock low pulse: false start
    p0 = pops[0];
    line[0] = 1'b0;
    tick(4);
    chk("fs_busy_mid", busy[0], 1);
    line[0] = 1'b1;
    tick(16);
    chk("fs_busy_end", busy[0], 0);
    tick(16);
    chk("fs_pops", pops[0] - p0, 0);

    // 8N2 0x5A with second stop bit low
    p0 = pops[2];
    send_bits(2, {5'b0, 1'b0, 1'b1, 8'h5A, 1'b0}, 11, -1);
    tick(8);
    expect_word("n2_ferr", 2, p0, 8'h5A, 0, 1);

    // Break of 20 bit-times
    p0 = pops[2];
    line[2] = 1'b0;
    tick(320);
    line[2] = 1'b1;
    tick(48);
    expect_word("brk", 2, p0, 8'h00, 0, 1);

    // Overrun: six frames with the consumer stalled
    rdy[0] = 1'b0;
    p0 = pops[0];
    for (int i = 1; i <= 6; i++) begin
      send_bits(0, {6'b0, 1'b1, 8'(i * 8'h11), 1'b0}, 10, -1);
      tick(16);
    end
    chk("ovr_count", cnt[0], 4);
    chk("ovr_flag",  ovr[0], 1);
    chk("ovr_valid", vld[0], 1);
    chk("ovr_head",  dout[0], 8'h11);
    oclr[0] = 1'b1;
    tick(1);
    oclr[0] = 1'b0;
    chk("ovr_clr", ovr[0], 0);
    rdy[0] = 1'b1;
    tick(8);
    chk("ovr_drained", pops[0] - p0, 4);
    chk("ovr_last",    int'(last[0][7:0]), 8'h44);
    chk("ovr_count0",  cnt[0], 0);

    // Reset in the middle of the data bits, then a clean frame
    p0 = pops[0];
    send_bits(0, {6'b0, 1'b1, 8'h77, 1'b0}, 4, -1);
    chk("mid_busy", busy[0], 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("mid_rst_busy", busy[0], 0);
    tick(32);
    send_bits(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, -1);
    tick(8);
    expect_word("mid_3c", 0, p0, 8'h3C, 0, 0);

    // One-clock glitch at oc=8 on a 1 bit (data bit 2) and a 0 bit (data bit 1)
    p0 = pops[0];
    send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 3);
    tick(8);
    expect_word("gl_hi", 0, p0, 8'hA5, 0, 0);
    p0 = pops[0];
    send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 2);
    tick(8);
    expect_word("gl_lo", 0, p0, 8'hA5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
